// File: rtl/raisin64_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Provides the dmem FSM state enum, word geometry and index-width helper.
package raisin64_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } dmem_state_t;

    localparam int DMEM_WORD_BYTES = 8;
    localparam int DMEM_OFFSET_W   = 3;

    // Word-index width for a storage of num_bytes bytes. A single-word
    // store still gets a 1-bit index so no zero-width vectors appear.
    function automatic int dmem_idx_w(input int num_bytes);
        int w;
        w = $clog2(num_bytes) - DMEM_OFFSET_W;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// 64-bit word storage: synchronous write, combinational read, no reset.
// Ports: clk, we, idx (word index), wdata (write word), rdata (read word).
module dmem_word_array
    import raisin64_mem_pkg::*;
#(
    parameter int WORDS = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with programmable wait states on a strobe/complete bus.
// Ports: clk, rst (async high), dmem_addr, dmem_din, dmem_rstrobe,
// dmem_wstrobe, dmem_dout (registered), dmem_cycle_complete (1-cycle pulse);
// dmem_fault (registered) only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder
    import raisin64_mem_pkg::*;
#(
    parameter int NUM_BYTES   = 256,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_din,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        dmem_fault,
`endif
    output logic [63:0] dmem_dout,
    output logic        dmem_cycle_complete
);

    localparam int IDX_W = dmem_idx_w(NUM_BYTES);
    localparam int WORDS = NUM_BYTES / DMEM_WORD_BYTES;
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] lat_idx;
    logic [63:0]      lat_din;
    logic             lat_we;
    logic             lat_mis;
    logic             strobe;
    logic             fire;
    logic             mem_we;
    logic [63:0]      rdata;
    logic [IDX_W-1:0] idx_in;

    assign strobe = dmem_rstrobe | dmem_wstrobe;
    // Access happens on the BUSY cycle whose counter has run out,
    // provided the request is still being held.
    assign fire   = (state == BUSY) && strobe && (cnt == '0);
    assign mem_we = fire && lat_we && !lat_mis;
    assign idx_in = dmem_addr[DMEM_OFFSET_W +: IDX_W] & IDX_MASK;

    wire unused_addr = ^{dmem_addr[63:DMEM_OFFSET_W+IDX_W],
                         dmem_addr[DMEM_OFFSET_W-1:0]};

    dmem_word_array #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (lat_idx),
        .wdata (lat_din),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            lat_idx             <= '0;
            lat_din             <= '0;
            lat_we              <= 1'b0;
            lat_mis             <= 1'b0;
            dmem_dout           <= '0;
            dmem_cycle_complete <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            dmem_fault          <= 1'b0;
`endif
        end else begin
            dmem_cycle_complete <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            dmem_fault          <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (strobe) begin
                        lat_idx <= idx_in;
                        lat_din <= dmem_din;
                        lat_we  <= dmem_wstrobe;
`ifdef DMEM_ALIGN_CHECK_EN
                        lat_mis <= (dmem_addr[DMEM_OFFSET_W-1:0] != '0);
`else
                        lat_mis <= 1'b0;
`endif
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!strobe) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!lat_we && !lat_mis) begin
                            dmem_dout <= rdata;
                        end
`ifdef DMEM_ALIGN_CHECK_EN
                        dmem_fault <= lat_mis;
`endif
                        dmem_cycle_complete <= 1'b1;
                        state               <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
